// File: rtl/rams64_port_arbiter.sv
// Two-requester arbiter in front of a 64x1 single-port distributed RAM (async read).
// Define RAMS64_ARB_INIT_EN to add a post-reset sweep that writes INIT_VAL to all 64 locations.
module rams64_port_arbiter #(
  parameter logic INIT_VAL  = 1'b0,
  parameter int   FIXED_PRI = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       req0,
  input  logic       we0,
  input  logic [5:0] adr0,
  input  logic       din0,
  output logic       gnt0,
  output logic       dout0,
  output logic       vld0,
  input  logic       req1,
  input  logic       we1,
  input  logic [5:0] adr1,
  input  logic       din1,
  output logic       gnt1,
  output logic       dout1,
  output logic       vld1,
  output logic [5:0] ram_adr,
  output logic       ram_i,
  output logic       ram_we,
  input  logic       ram_o,
  output logic       busy
);

  typedef enum logic {INIT, RUN} state_e;

`ifdef RAMS64_ARB_INIT_EN
  localparam state_e ResetState = INIT;
`else
  localparam state_e ResetState = RUN;
`endif

  state_e     state_q;
  logic [5:0] sweepCnt_q;
  logic [5:0] adrHold_q;
  logic       favour1_q;
  logic       dout0_q, dout1_q;
  logic       vld0_q, vld1_q;
  logic       both;
  logic       win0, win1;

  // Grants are combinational and forced low while reset is asserted.
  always_comb begin
    both = req0 & req1;
    win0 = 1'b0;
    win1 = 1'b0;
    if (state_q == RUN && !RST) begin
      if (both) begin
        if (FIXED_PRI != 0 || !favour1_q) win0 = 1'b1;
        else                              win1 = 1'b1;
      end else begin
        win0 = req0;
        win1 = req1;
      end
    end
  end

  // RAM port mux; with no winner the address holds its last driven value.
  always_comb begin
    ram_adr = adrHold_q;
    ram_i   = 1'b0;
    ram_we  = 1'b0;
    if (state_q == INIT) begin
      ram_adr = sweepCnt_q;
      if (!RST) begin
        ram_i  = INIT_VAL;
        ram_we = 1'b1;
      end
    end else if (win0) begin
      ram_adr = adr0;
      ram_i   = din0;
      ram_we  = we0;
    end else if (win1) begin
      ram_adr = adr1;
      ram_i   = din1;
      ram_we  = we1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ResetState;
      sweepCnt_q <= 6'd0;
      adrHold_q  <= 6'd0;
      favour1_q  <= 1'b0;
      dout0_q    <= 1'b0;
      dout1_q    <= 1'b0;
      vld0_q     <= 1'b0;
      vld1_q     <= 1'b0;
    end else begin
      vld0_q <= win0 & ~we0;
      vld1_q <= win1 & ~we1;
      if (win0 && !we0) dout0_q <= ram_o;
      if (win1 && !we1) dout1_q <= ram_o;
      if (win0)      adrHold_q <= adr0;
      else if (win1) adrHold_q <= adr1;
      // The pointer only moves on contended cycles.
      if (state_q == RUN && both && FIXED_PRI == 0) favour1_q <= ~favour1_q;
      if (state_q == INIT) begin
        sweepCnt_q <= sweepCnt_q + 6'd1;
        adrHold_q  <= sweepCnt_q;
        if (sweepCnt_q == 6'd63) state_q <= RUN;
      end
    end
  end

  assign gnt0  = win0;
  assign gnt1  = win1;
  assign dout0 = dout0_q;
  assign dout1 = dout1_q;
  assign vld0  = vld0_q;
  assign vld1  = vld1_q;

`ifdef RAMS64_ARB_INIT_EN
  assign busy = (state_q == INIT);
`else
  assign busy = 1'b0;
`endif

endmodule
